spi_core: RTL and testbench

- SPI master for a single full-duplex transfer of DWIDTH bits, MSB first, with sclk idle low.
- A host write loads a word. The core shifts it out on mosi and shifts the slave's word in from miso. At completion the received word is presented on dout.
- Target slave: samples mosi on sclk rising and updates miso on sclk falling. It sits between a register-interface host and an external shift-register slave.

---
 rtl/spi_core.sv | 135 +++++++++++++
 tb/tb_spi_core.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_core.sv
//------------------------------------------------------------------------------
// Module  : spi_core
// Purpose : SPI master, one full-duplex DWIDTH-bit transfer per host write,
//           MSB first, sclk idle low.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_core #(
  parameter int DWIDTH  = 8,
  parameter int CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic              done
);

  localparam int unsigned c_CNT_W = $clog2(DWIDTH + 1);
  localparam int unsigned c_DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [c_CNT_W-1:0] c_BITS     = c_CNT_W'(DWIDTH);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HIGH   = 2'd1,
    S_LOW    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [c_DIV_W-1:0]  r_div;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [DWIDTH-1:0]   r_tx;
  logic [DWIDTH-1:0]   r_rx;
  logic [DWIDTH-1:0]   r_dout;
  logic                r_mosi;
  logic                r_sclk;
  logic                r_done;

  logic                w_start;
  logic                w_phase_first;
  logic                w_phase_end;
  logic [c_CNT_W-1:0]  w_cnt_inc;
  logic [c_CNT_W-1:0]  w_cnt_now;

  assign w_start       = cs && wr && !rd && r_done && (r_state == S_IDLE);
  assign w_phase_first = (r_div == '0);
  assign w_phase_end   = (r_div == c_DIV_LAST);
  assign w_cnt_inc     = r_cnt + 1'b1;
  // With CLK_DIV=1 the LOW entry and exit share one edge, so the count
  // has not been bumped yet when the exit decision is made.
  assign w_cnt_now     = w_phase_first ? w_cnt_inc : r_cnt;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_HIGH;
      S_HIGH:   if (w_phase_end) w_next = S_LOW;
      S_LOW:    if (w_phase_end) w_next = (w_cnt_now < c_BITS) ? S_HIGH : S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div  <= '0;
      r_cnt  <= '0;
      r_tx   <= '0;
      r_rx   <= '0;
      r_dout <= '0;
      r_mosi <= 1'b0;
      r_sclk <= 1'b0;
      r_done <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_div <= '0;
          if (w_start) begin
            r_tx   <= din;
            r_mosi <= din[DWIDTH-1];
            r_cnt  <= '0;
            r_done <= 1'b0;
          end
        end
        S_HIGH: begin
          if (w_phase_first) begin
            r_sclk <= 1'b1;
            // Slave bit presented after the previous falling edge.
            if (r_cnt != '0) r_rx <= {r_rx[DWIDTH-2:0], miso};
          end
          r_div <= w_phase_end ? '0 : r_div + 1'b1;
        end
        S_LOW: begin
          if (w_phase_first) begin
            r_sclk <= 1'b0;
            r_tx   <= r_tx << 1;
            r_mosi <= (w_cnt_inc < c_BITS) ? r_tx[DWIDTH-2] : 1'b0;
            r_cnt  <= w_cnt_inc;
          end
          r_div <= w_phase_end ? '0 : r_div + 1'b1;
        end
        S_FINISH: begin
          r_dout <= {r_rx[DWIDTH-2:0], miso};
          r_done <= 1'b1;
          r_sclk <= 1'b0;
          r_div  <= '0;
        end
        default: r_div <= '0;
      endcase
    end
  end

  assign dout = r_dout;
  assign mosi = r_mosi;
  assign sclk = r_sclk;
  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_spi_core.sv
//------------------------------------------------------------------------------
// Module  : tb_spi_core
// Purpose : Directed self-checking bench for spi_core with a shift-register
//           slave model; covers CLK_DIV=1 and CLK_DIV=3 instances.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cs  = 1'b0;
  logic       rd  = 1'b0;
  logic       wr1 = 1'b0;
  logic       wr3 = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] din = 8'h00;
  logic       miso1 = 1'b0;
  logic       miso3 = 1'b0;

  wire  [7:0] dout1, dout3;
  wire        mosi1, mosi3, sclk1, sclk3, done1, done3;

  int checks = 0;
  int errors = 0;
  int lat, run_min, run_max;

  logic [7:0] s1 = 8'h00, s3 = 8'h00, seen1 = 8'h00, seen3 = 8'h00;
  logic       b1 = 1'b0, b3 = 1'b0;
  int         rises1 = 0, rises3 = 0;

  spi_core #(.DWIDTH(8), .CLK_DIV(1)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr1), .din(din),
    .dout(dout1), .miso(miso1), .mosi(mosi1), .sclk(sclk1), .done(done1)
  );

  spi_core #(.DWIDTH(8), .CLK_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr3), .din(din),
    .dout(dout3), .miso(miso3), .mosi(mosi3), .sclk(sclk3), .done(done3)
  );

  always #5 clk = ~clk;

  // Slave: samples mosi on sclk rise, shifts and drives miso on sclk fall.
  always @(posedge sclk1) begin b1 = mosi1; seen1 = {seen1[6:0], mosi1}; rises1++; end
  always @(negedge sclk1) begin miso1 = s1[7]; s1 = {s1[6:0], b1}; end
  always @(posedge sclk3) begin b3 = mosi3; seen3 = {seen3[6:0], mosi3}; rises3++; end
  always @(negedge sclk3) begin miso3 = s3[7]; s3 = {s3[6:0], b3}; end

  wire       done_s = sel ? done3 : done1;
  wire       sclk_s = sel ? sclk3 : sclk1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic v);
    if (sel) wr3 = v;
    else     wr1 = v;
  endtask

  // Runs one transfer on the selected instance; inject >= 0 raises a stray
  // write with din=FF at that cycle of the transfer.
  task automatic xfer(input logic [7:0] d, input logic [7:0] pre, input int inject,
                      input int exp_lat);
    logic prev, cur, started;
    int   run;
    if (sel) begin s3 = pre; seen3 = 8'h00; rises3 = 0; end
    else     begin s1 = pre; seen1 = 8'h00; rises1 = 0; end
    din = d; cs = 1'b1; set_wr(1'b1);
    tick;
    set_wr(1'b0); cs = 1'b0;
    checks++;
    if (done_s !== 1'b0) begin
      errors++; $display("FAIL start_done_low: got %b want 0", done_s);
    end
    lat = 0; run = 0; prev = 1'b0; started = 1'b0; run_min = 1000; run_max = 0;
    while (done_s !== 1'b1 && lat < 300) begin
      if (lat == inject) begin cs = 1'b1; set_wr(1'b1); din = 8'hFF; end
      else               begin cs = 1'b0; set_wr(1'b0); end
      tick;
      lat++;
      cur = sclk_s;
      if (cur !== prev) begin
        if (started) begin
          if (run < run_min) run_min = run;
          if (run > run_max) run_max = run;
        end
        started = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      prev = cur;
    end
    cs = 1'b0; set_wr(1'b0);
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL latency: got %0d cycles want %0d", lat, exp_lat);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick;
    miso1 = 1'b1; miso3 = 1'b1;
    tick;
    miso1 = 1'b0; miso3 = 1'b0;
    tick;
    checks++; if (sclk1 !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk1); end
    checks++; if (mosi1 !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi1); end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL reset_done: got %b want 1", done1); end
    checks++; if (dout1 !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout1); end
    checks++; if (done3 !== 1'b1 || sclk3 !== 1'b0 || dout3 !== 8'h00) begin
      errors++; $display("FAIL reset_div3: got done=%b sclk=%b dout=%h want 1 0 00", done3, sclk3, dout3);
    end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_single;
    sel = 1'b0;
    xfer(8'hAA, 8'h3C, -1, 17);
    checks++; if (dout1 !== 8'h3C) begin errors++; $display("FAIL single_dout: got %h want 3c", dout1); end
    checks++; if (seen1 !== 8'hAA) begin errors++; $display("FAIL single_mosi_bits: got %h want aa", seen1); end
    checks++; if (rises1 != 8) begin errors++; $display("FAIL single_rises: got %0d want 8", rises1); end
    checks++; if (s1 !== 8'hAA) begin errors++; $display("FAIL single_slave: got %h want aa", s1); end
    checks++; if (run_min != 1 || run_max != 1) begin
      errors++; $display("FAIL single_phase: got %0d..%0d want 1", run_min, run_max);
    end
  endtask

  task automatic test_round_trip;
    sel = 1'b0;
    xfer(8'h55, s1, -1, 17);
    checks++; if (dout1 !== 8'hAA) begin errors++; $display("FAIL rt_dout: got %h want aa", dout1); end
    checks++; if (s1 !== 8'h55) begin errors++; $display("FAIL rt_slave: got %h want 55", s1); end
  endtask

  task automatic test_back_to_back;
    sel = 1'b0;
    xfer(8'h0F, 8'hE1, -1, 17);
    xfer(8'hF0, 8'h96, -1, 17);
    checks++; if (dout1 !== 8'h96) begin errors++; $display("FAIL b2b_dout: got %h want 96", dout1); end
    checks++; if (s1 !== 8'hF0) begin errors++; $display("FAIL b2b_slave: got %h want f0", s1); end
  endtask

  task automatic test_ignored;
    sel = 1'b0;
    xfer(8'hC3, 8'h55, 5, 17);
    checks++; if (seen1 !== 8'hC3) begin errors++; $display("FAIL ign_mid_mosi: got %h want c3", seen1); end
    checks++; if (dout1 !== 8'h55) begin errors++; $display("FAIL ign_mid_dout: got %h want 55", dout1); end
    rises1 = 0;
    cs = 1'b1; wr1 = 1'b1; rd = 1'b1; din = 8'h12;
    tick;
    cs = 1'b0; wr1 = 1'b0; rd = 1'b0;
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL ign_rd_done: got %b want 1", done1); end
    tick;
    checks++; if (done1 !== 1'b1 || sclk1 !== 1'b0 || rises1 != 0) begin
      errors++; $display("FAIL ign_rd_idle: got done=%b sclk=%b rises=%0d want 1 0 0", done1, sclk1, rises1);
    end
  endtask

  task automatic test_reset_mid;
    int k;
    sel = 1'b0;
    s1 = 8'h77; rises1 = 0;
    din = 8'hC3; cs = 1'b1; wr1 = 1'b1;
    tick;
    cs = 1'b0; wr1 = 1'b0;
    k = 0;
    while (rises1 < 3 && k < 100) begin tick; k++; end
    checks++; if (rises1 != 3) begin errors++; $display("FAIL rstmid_reach: got %0d rises want 3", rises1); end
    rst = 1'b0;
    tick;
    checks++; if (sclk1 !== 1'b0 || done1 !== 1'b1 || dout1 !== 8'h00) begin
      errors++; $display("FAIL rstmid_state: got sclk=%b done=%b dout=%h want 0 1 00", sclk1, done1, dout1);
    end
    rst = 1'b1;
    tick;
    xfer(8'hA5, 8'h5A, -1, 17);
    checks++; if (dout1 !== 8'h5A) begin errors++; $display("FAIL rstmid_dout: got %h want 5a", dout1); end
    checks++; if (seen1 !== 8'hA5) begin errors++; $display("FAIL rstmid_mosi: got %h want a5", seen1); end
  endtask

  task automatic test_clkdiv3;
    sel = 1'b1;
    xfer(8'h81, 8'h96, -1, 49);
    checks++; if (dout3 !== 8'h96) begin errors++; $display("FAIL div3_dout: got %h want 96", dout3); end
    checks++; if (seen3 !== 8'h81) begin errors++; $display("FAIL div3_mosi: got %h want 81", seen3); end
    checks++; if (rises3 != 8) begin errors++; $display("FAIL div3_rises: got %0d want 8", rises3); end
    checks++; if (run_min != 3 || run_max != 3) begin
      errors++; $display("FAIL div3_phase: got %0d..%0d want 3", run_min, run_max);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_trip;
    test_back_to_back;
    test_ignored;
    test_reset_mid;
    test_clkdiv3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
